// File: rtl/i2c_apb_fifo.sv
// rtl/i2c_apb_fifo.sv - first-word-fall-through FIFO between the APB slave and the I2C engine
// Provides empty/full/threshold flags and a sticky overflow/underflow error for PSLVERR.
module i2c_apb_fifo #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int THRESHOLD = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] WR_DATA,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] RD_DATA,
  input  logic              CLR_ERR,
  output logic              FULL,
  output logic              EMPTY,
  output logic [AWIDTH:0]   COUNT,
  output logic              LEVEL_HIT,
  output logic              ERROR
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              error_q, error_d;
  logic              wr_acc, rd_acc, overflow, underflow;

  assign FULL      = (count_q == (AWIDTH+1)'(DEPTH));
  assign EMPTY     = (count_q == '0);
  assign LEVEL_HIT = (count_q >= (AWIDTH+1)'(THRESHOLD));
  assign COUNT     = count_q;
  assign ERROR     = error_q;
  assign RD_DATA   = EMPTY ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign wr_acc    = WR_EN & (~FULL | RD_EN);
  assign rd_acc    = RD_EN & ~EMPTY;
  assign overflow  = WR_EN & FULL & ~RD_EN;
  assign underflow = RD_EN & EMPTY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + (AWIDTH+1)'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - (AWIDTH+1)'(1);
    // A fresh error outranks a clear requested in the same cycle.
    if (overflow || underflow) error_d = 1'b1;
    else if (CLR_ERR)          error_d = 1'b0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET && wr_acc) mem_q[wr_ptr_q] <= WR_DATA;
  end

endmodule

// File: tb/tb_i2c_apb_fifo.sv
// tb/tb_i2c_apb_fifo.sv - directed self-checking bench for i2c_apb_fifo
module tb_i2c_apb_fifo;

  logic        PCLK = 1'b0;
  logic        PRESET, WR_EN, RD_EN, CLR_ERR;
  logic [31:0] WR_DATA;
  logic [31:0] RD_DATA;
  logic        FULL, EMPTY, LEVEL_HIT, ERROR;
  logic [4:0]  COUNT;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_w;

  i2c_apb_fifo #(.DWIDTH(32), .AWIDTH(4), .THRESHOLD(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .CLR_ERR(CLR_ERR), .FULL(FULL),
    .EMPTY(EMPTY), .COUNT(COUNT), .LEVEL_HIT(LEVEL_HIT), .ERROR(ERROR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    WR_EN = 1'b0; RD_EN = 1'b0; CLR_ERR = 1'b0; PRESET = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    WR_EN = 1'b1; WR_DATA = d;
    step();
    WR_EN = 1'b0;
  endtask

  task automatic pop();
    RD_EN = 1'b1;
    step();
    RD_EN = 1'b0;
  endtask

  initial begin
    idle();
    WR_DATA = '0;
    PRESET = 1'b1;
    step(); step();
    PRESET = 1'b0;
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_empty", 32'(EMPTY), 1);
    chk("rst_full", 32'(FULL), 0);
    chk("rst_level", 32'(LEVEL_HIT), 0);
    chk("rst_error", 32'(ERROR), 0);
    chk("rst_rdata", RD_DATA, 0);

    // Three writes: head is the first word, below threshold
    push(32'h11); push(32'h22); push(32'h33);
    chk("w3_count", 32'(COUNT), 3);
    chk("w3_empty", 32'(EMPTY), 0);
    chk("w3_rdata", RD_DATA, 32'h11);
    chk("w3_level", 32'(LEVEL_HIT), 0);
    PRESET = 1'b1; step(); PRESET = 1'b0;

    // Fill to full, then overflow attempt
    for (int i = 0; i < 16; i++) push(32'(i));
    chk("full_flag", 32'(FULL), 1);
    chk("full_count", 32'(COUNT), 16);
    chk("full_err0", 32'(ERROR), 0);
    push(32'hAA);
    chk("ovf_count", 32'(COUNT), 16);
    chk("ovf_err", 32'(ERROR), 1);
    chk("ovf_head", RD_DATA, 32'h00);
    CLR_ERR = 1'b1; step(); CLR_ERR = 1'b0;
    chk("clr_err", 32'(ERROR), 0);

    // Simultaneous push/pop while full
    WR_EN = 1'b1; RD_EN = 1'b1; WR_DATA = 32'h55;
    step();
    idle();
    chk("fpp_count", 32'(COUNT), 16);
    chk("fpp_err", 32'(ERROR), 0);
    chk("fpp_head", RD_DATA, 32'h01);
    for (int i = 1; i <= 16; i++) begin
      exp_w = (i == 16) ? 32'h55 : 32'(i);
      chk("drain", RD_DATA, exp_w);
      pop();
    end
    chk("drain_empty", 32'(EMPTY), 1);
    chk("drain_rdata", RD_DATA, 0);
    chk("drain_err", 32'(ERROR), 0);

    // Underflow and clear
    pop();
    chk("udf_err", 32'(ERROR), 1);
    chk("udf_count", 32'(COUNT), 0);
    chk("udf_rdata", RD_DATA, 0);
    CLR_ERR = 1'b1; step(); CLR_ERR = 1'b0;
    chk("udf_clr", 32'(ERROR), 0);

    // Push and pop together on empty: push taken, pop flagged
    WR_EN = 1'b1; RD_EN = 1'b1; WR_DATA = 32'h77;
    step();
    idle();
    chk("epp_count", 32'(COUNT), 1);
    chk("epp_err", 32'(ERROR), 1);
    chk("epp_rdata", RD_DATA, 32'h77);
    pop();
    // Clear and new underflow in the same cycle: set wins
    CLR_ERR = 1'b1; RD_EN = 1'b1;
    step();
    idle();
    chk("setwins", 32'(ERROR), 1);
    CLR_ERR = 1'b1; step(); CLR_ERR = 1'b0;
    chk("setwins_clr", 32'(ERROR), 0);

    // Streaming: 40 cycles of push+pop at level 3, pointers wrap twice
    for (int i = 0; i < 3; i++) begin
      push(32'h100 + 32'(i));
      sb.push_back(32'h100 + 32'(i));
    end
    for (int i = 0; i < 40; i++) begin
      chk("stream_data", RD_DATA, sb[0]);
      WR_EN = 1'b1; RD_EN = 1'b1; WR_DATA = 32'h200 + 32'(i);
      step();
      void'(sb.pop_front());
      sb.push_back(32'h200 + 32'(i));
      chk("stream_count", 32'(COUNT), 3);
    end
    idle();
    chk("stream_err", 32'(ERROR), 0);
    while (sb.size() > 0) begin
      chk("stream_tail", RD_DATA, sb.pop_front());
      pop();
    end
    chk("stream_empty", 32'(EMPTY), 1);

    // Leave ERROR set, fill to threshold, then reset with a push in flight
    pop();
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i));
    chk("lvl3", 32'(LEVEL_HIT), 0);
    push(32'h303);
    chk("lvl4", 32'(LEVEL_HIT), 1);
    chk("pre_rst_err", 32'(ERROR), 1);
    PRESET = 1'b1; WR_EN = 1'b1; WR_DATA = 32'hDEAD;
    step();
    idle();
    chk("mrst_count", 32'(COUNT), 0);
    chk("mrst_empty", 32'(EMPTY), 1);
    chk("mrst_err", 32'(ERROR), 0);
    chk("mrst_rdata", RD_DATA, 0);
    chk("mrst_level", 32'(LEVEL_HIT), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
